// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: datapath width, ALU opcodes, EX/MEM pipeline entry.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package riscv_pkg;

    localparam int XLEN = 32;

    // ALU operation encodings, shared between the ALU and its decoder.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    // One entry travelling from EX into MEM.
    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } ex_mem_t;

    localparam int EX_MEM_W = $bits(ex_mem_t);

    // BEQ is taken when the ALU difference is zero, BNE when it is not.
    function automatic logic branch_taken(input logic branch,
                                          input logic zero,
                                          input logic bne);
        return branch & (zero ^ bne);
    endfunction

    // Branch target; wraps silently modulo 2^XLEN.
    function automatic logic [XLEN-1:0] branch_target(input logic [XLEN-1:0] pc,
                                                      input logic [XLEN-1:0] imm);
        return pc + imm;
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-slot skid buffer (head + skid) carrying a WIDTH-bit payload in order.
// Latency: 1 cycle from accept to out_vld_o when the head is free or draining.
// Backpressure: in_rdy_o is registered; it drops once the skid slot fills and rises the cycle after it empties.
module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld_i,
    output logic             in_rdy_o,
    input  logic [WIDTH-1:0] in_dat_i,
    output logic             out_vld_o,
    input  logic             out_rdy_i,
    output logic [WIDTH-1:0] out_dat_o
);

    logic             head_vld_q, head_vld_d;
    logic [WIDTH-1:0] head_dat_q, head_dat_d;
    logic             skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
    logic             rdy_q, rdy_d;

    logic in_fire;
    logic head_free;

    assign in_fire   = in_vld_i & rdy_q;
    // The head slot can take a new entry this edge if it is empty or being consumed.
    assign head_free = !head_vld_q || out_rdy_i;

    // Next-state: refill head from skid first to keep order, then from the input.
    always_comb begin
        head_vld_d = head_vld_q;
        head_dat_d = head_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;

        if (head_free) begin
            if (skid_vld_q) begin
                // Older skid entry moves up; a new entry (if any) takes its place.
                head_vld_d = 1'b1;
                head_dat_d = skid_dat_q;
                skid_vld_d = in_fire;
                if (in_fire) begin
                    skid_dat_d = in_dat_i;
                end
            end else begin
                head_vld_d = in_fire;
                if (in_fire) begin
                    head_dat_d = in_dat_i;
                end
            end
        end else if (in_fire) begin
            // Head stalled; rdy_q high guarantees the skid slot is empty.
            skid_vld_d = 1'b1;
            skid_dat_d = in_dat_i;
        end

        rdy_d = !skid_vld_d;
    end

    // Slot registers; reset discards both entries and holds off upstream for a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_vld_q <= 1'b0;
            head_dat_q <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
            rdy_q      <= 1'b0;
        end else begin
            head_vld_q <= head_vld_d;
            head_dat_q <= head_dat_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
            rdy_q      <= rdy_d;
        end
    end

    assign in_rdy_o  = rdy_q;
    assign out_vld_o = head_vld_q;
    assign out_dat_o = head_dat_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: captures ALU result and control, resolves branches, feeds MEM and forwarding.
// Latency: 1 cycle from accept to mem_valid (head free or draining); redirect pulses 1 cycle after a taken accept.
// Backpressure: mem_ready low parks one extra entry in the skid slot, then registered ex_ready drops.
module ex_mem_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst,

    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic            ex_zero,
    input  logic [XLEN-1:0] ex_rs2_data,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [4:0]      ex_rd,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic            ex_mem_write,
    input  logic            ex_branch,
    input  logic            ex_bne,

    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_alu_result,
    output logic [XLEN-1:0] mem_store_data,
    output logic [4:0]      mem_rd,
    output logic            mem_reg_write,
    output logic            mem_mem_read,
    output logic            mem_mem_write,

    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,

    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data
);

    ex_mem_t         cap_dat;
    ex_mem_t         head_dat;
    logic [EX_MEM_W-1:0] head_bits;
    logic            ex_fire;
    logic            taken;
    logic [XLEN-1:0] target;

    logic            redir_vld_q, redir_vld_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;

    assign ex_fire = ex_valid & ex_ready;
    assign taken   = branch_taken(ex_branch, ex_zero, ex_bne);
    assign target  = branch_target(ex_pc, ex_imm);

    // Build the entry: x0 never gets written, and a branch carries no side effects into MEM.
    always_comb begin
        cap_dat            = '0;
        cap_dat.result     = ex_alu_result;
        cap_dat.store_data = ex_rs2_data;
        cap_dat.rd         = ex_rd;
        cap_dat.reg_write  = ex_reg_write & (ex_rd != 5'd0) & !ex_branch;
        cap_dat.mem_read   = ex_mem_read  & !ex_branch;
        cap_dat.mem_write  = ex_mem_write & !ex_branch;
    end

    skid_buffer #(
        .WIDTH (EX_MEM_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_vld_i  (ex_valid),
        .in_rdy_o  (ex_ready),
        .in_dat_i  (cap_dat),
        .out_vld_o (mem_valid),
        .out_rdy_i (mem_ready),
        .out_dat_o (head_bits)
    );

    assign head_dat = ex_mem_t'(head_bits);

    // Redirect is a single-cycle pulse; PC is zeroed whenever no pulse is pending.
    always_comb begin
        redir_vld_d = ex_fire & taken;
        redir_pc_d  = (ex_fire & taken) ? target : '0;
    end

    // Redirect register; reset cancels any pending pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            redir_vld_q <= 1'b0;
            redir_pc_q  <= '0;
        end else begin
            redir_vld_q <= redir_vld_d;
            redir_pc_q  <= redir_pc_d;
        end
    end

    assign redirect_valid = redir_vld_q;
    assign redirect_pc    = redir_pc_q;

    assign mem_alu_result = head_dat.result;
    assign mem_store_data = head_dat.store_data;
    assign mem_rd         = head_dat.rd;
    assign mem_reg_write  = head_dat.reg_write;
    assign mem_mem_read   = head_dat.mem_read;
    assign mem_mem_write  = head_dat.mem_write;

    // Loads are excluded: their value is not known until MEM completes.
    assign fwd_valid = mem_valid & head_dat.reg_write & !head_dat.mem_read;
    assign fwd_rd    = head_dat.rd;
    assign fwd_data  = head_dat.result;

endmodule

// File: tb/tb_ex_mem_stage.sv
module tb_ex_mem_stage;
    import riscv_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_alu_result;
    logic            ex_zero;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;
    logic [4:0]      ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_branch;
    logic            ex_bne;
    logic            mem_valid;
    logic            mem_ready;
    logic [XLEN-1:0] mem_alu_result;
    logic [XLEN-1:0] mem_store_data;
    logic [4:0]      mem_rd;
    logic            mem_reg_write;
    logic            mem_mem_read;
    logic            mem_mem_write;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            fwd_valid;
    logic [4:0]      fwd_rd;
    logic [XLEN-1:0] fwd_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_ready       (ex_ready),
        .ex_alu_result  (ex_alu_result),
        .ex_zero        (ex_zero),
        .ex_rs2_data    (ex_rs2_data),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_rd          (ex_rd),
        .ex_reg_write   (ex_reg_write),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_write   (ex_mem_write),
        .ex_branch      (ex_branch),
        .ex_bne         (ex_bne),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_alu_result (mem_alu_result),
        .mem_store_data (mem_store_data),
        .mem_rd         (mem_rd),
        .mem_reg_write  (mem_reg_write),
        .mem_mem_read   (mem_mem_read),
        .mem_mem_write  (mem_mem_write),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fwd_valid      (fwd_valid),
        .fwd_rd         (fwd_rd),
        .fwd_data       (fwd_data)
    );

    typedef struct {
        logic        vld;
        logic [31:0] res;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        zero, rw, mr, mw, br, bne;
        logic        e_mvld;
        logic        e_rw, e_mr, e_mw;
        logic        e_redir;
        logic [31:0] e_rpc;
        logic        e_fwd;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic [31:0] res, input logic [31:0] rs2,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd,
                         input logic zero, input logic rw, input logic mr, input logic mw,
                         input logic br, input logic bne);
        ex_valid      = vld;
        ex_alu_result = res;
        ex_rs2_data   = rs2;
        ex_pc         = pc;
        ex_imm        = imm;
        ex_rd         = rd;
        ex_zero       = zero;
        ex_reg_write  = rw;
        ex_mem_read   = mr;
        ex_mem_write  = mw;
        ex_branch     = br;
        ex_bne        = bne;
    endtask

    function automatic vec_t mk(input logic vld, input logic [31:0] res, input logic [31:0] rs2,
                                input logic [31:0] pc, input logic [31:0] imm, input logic [4:0] rd,
                                input logic zero, input logic rw, input logic mr, input logic mw,
                                input logic br, input logic bne,
                                input logic e_mvld, input logic e_rw, input logic e_mr, input logic e_mw,
                                input logic e_redir, input logic [31:0] e_rpc, input logic e_fwd);
        vec_t v;
        v.vld = vld; v.res = res; v.rs2 = rs2; v.pc = pc; v.imm = imm; v.rd = rd;
        v.zero = zero; v.rw = rw; v.mr = mr; v.mw = mw; v.br = br; v.bne = bne;
        v.e_mvld = e_mvld; v.e_rw = e_rw; v.e_mr = e_mr; v.e_mw = e_mw;
        v.e_redir = e_redir; v.e_rpc = e_rpc; v.e_fwd = e_fwd;
        return v;
    endfunction

    initial begin
        // Streaming ALU ops, results 1..8, rd = 1..8.
        for (int i = 0; i < 8; i++) begin
            vecs[i] = mk(1'b1, 32'(i + 1), 32'h100 + 32'(i), 32'h0, 32'h0, 5'(i + 1),
                         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                         1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        end
        // Load: writes a register but is not forwardable.
        vecs[8]  = mk(1'b1, 32'h40, 32'h0, 32'h0, 32'h0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                      1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        // Store.
        vecs[9]  = mk(1'b1, 32'h44, 32'hDEADBEEF, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                      1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        // Write to x0 is suppressed.
        vecs[10] = mk(1'b1, 32'h55, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        // BEQ taken, control bits forced off.
        vecs[11] = mk(1'b1, 32'h0, 32'h7, 32'h100, 32'h20, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                      1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h120, 1'b0);
        // BNE with zero=1: not taken.
        vecs[12] = mk(1'b1, 32'h0, 32'h0, 32'h200, 32'h40, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        // BNE taken with wrapping target.
        vecs[13] = mk(1'b1, 32'h1, 32'h0, 32'hFFFFFFF0, 32'h20, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                      1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00000010, 1'b0);
        // BEQ with zero=0: not taken.
        vecs[14] = mk(1'b1, 32'h9, 32'h0, 32'h300, 32'h8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        // Bubble.
        vecs[15] = mk(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        // ---------------- Reset with ex_valid high ----------------
        rst       = 1'b1;
        mem_ready = 1'b1;
        drive(1'b1, 32'hAAAA, 32'hBBBB, 32'h100, 32'h20, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("rst_mem_valid", 32'(mem_valid), 32'h0);
            check("rst_ex_ready", 32'(ex_ready), 32'h0);
            check("rst_redirect_valid", 32'(redirect_valid), 32'h0);
            check("rst_fwd_valid", 32'(fwd_valid), 32'h0);
        end
        check("rst_mem_alu_result", mem_alu_result, 32'h0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        check("rst_fwd_data", fwd_data, 32'h0);
        rst = 1'b0;
        step();
        check("post_rst_ex_ready", 32'(ex_ready), 32'h1);
        check("post_rst_mem_valid", 32'(mem_valid), 32'h0);
        check("post_rst_redirect", 32'(redirect_valid), 32'h0);

        // ---------------- Table-driven stream, mem_ready=1 ----------------
        for (int i = 0; i < 16; i++) begin
            check("vec_ex_ready", 32'(ex_ready), 32'h1);
            drive(vecs[i].vld, vecs[i].res, vecs[i].rs2, vecs[i].pc, vecs[i].imm, vecs[i].rd,
                  vecs[i].zero, vecs[i].rw, vecs[i].mr, vecs[i].mw, vecs[i].br, vecs[i].bne);
            step();
            check("vec_mem_valid", 32'(mem_valid), 32'(vecs[i].e_mvld));
            if (vecs[i].e_mvld) begin
                check("vec_mem_alu_result", mem_alu_result, vecs[i].res);
                check("vec_mem_store_data", mem_store_data, vecs[i].rs2);
                check("vec_mem_rd", 32'(mem_rd), 32'(vecs[i].rd));
                check("vec_mem_reg_write", 32'(mem_reg_write), 32'(vecs[i].e_rw));
                check("vec_mem_mem_read", 32'(mem_mem_read), 32'(vecs[i].e_mr));
                check("vec_mem_mem_write", 32'(mem_mem_write), 32'(vecs[i].e_mw));
                check("vec_fwd_rd", 32'(fwd_rd), 32'(vecs[i].rd));
                check("vec_fwd_data", fwd_data, vecs[i].res);
            end
            check("vec_fwd_valid", 32'(fwd_valid), 32'(vecs[i].e_fwd));
            check("vec_redirect_valid", 32'(redirect_valid), 32'(vecs[i].e_redir));
            check("vec_redirect_pc", redirect_pc, vecs[i].e_rpc);
        end

        // ---------------- Backpressure ----------------
        drive(1'b1, 32'hA1, 32'h0, 32'h0, 32'h0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("bp_head_a1", mem_alu_result, 32'hA1);
        mem_ready = 1'b0;
        drive(1'b1, 32'hA2, 32'h0, 32'h0, 32'h0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        // A2 parked in skid; upstream must now stall.
        check("bp_ready_low", 32'(ex_ready), 32'h0);
        check("bp_head_frozen", mem_alu_result, 32'hA1);
        drive(1'b1, 32'hA3, 32'h0, 32'h0, 32'h0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step();
            check("bp_hold_ready", 32'(ex_ready), 32'h0);
            check("bp_hold_valid", 32'(mem_valid), 32'h1);
            check("bp_hold_head", mem_alu_result, 32'hA1);
            check("bp_hold_rd", 32'(mem_rd), 32'd1);
        end
        mem_ready = 1'b1;
        step();
        // A1 consumed, skid A2 promoted, A3 still waiting upstream.
        check("bp_rel_head_a2", mem_alu_result, 32'hA2);
        check("bp_rel_ready", 32'(ex_ready), 32'h1);
        step();
        check("bp_head_a3", mem_alu_result, 32'hA3);
        check("bp_a3_valid", 32'(mem_valid), 32'h1);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("bp_drained", 32'(mem_valid), 32'h0);

        // ---------------- Reset mid-operation ----------------
        mem_ready = 1'b0;
        drive(1'b1, 32'hB1, 32'h0, 32'h0, 32'h0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h0, 32'h0, 32'h200, 32'h8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
        check("mid_both_full", 32'(ex_ready), 32'h0);
        check("mid_redirect_pc", redirect_pc, 32'h208);
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        check("mid_rst_redirect", 32'(redirect_valid), 32'h0);
        check("mid_rst_mem_valid", 32'(mem_valid), 32'h0);
        rst = 1'b0;
        mem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("mid_after_mem_valid", 32'(mem_valid), 32'h0);
            check("mid_after_redirect", 32'(redirect_valid), 32'h0);
        end
        check("mid_after_ready", 32'(ex_ready), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
